// File: rtl/busarb_if.sv
// ---------------------------------------------------------------------------
// busarb_if
// Purpose : Bundles every signal between the two bus masters, the arbiter and
//           the downstream bus controller into one interface.
// Modports:
//   slave  - the arbiter's view. It takes the master requests and the bus
//            controller responses in, and drives the bus request, the
//            per-master responses and the timeout status out.
//   master - the environment's view (masters and bus controller). It is the
//            mirror image of slave.
// Signals :
//   m0_*/m1_*    per-master request (en, wr, size, addr, data_out) and
//                response (data_in, wt)
//   bus_*        request to the bus controller (en, wr, size, addr,
//                data_out) and its response (data_in, wt)
//   bus_to       one-cycle pulse when a transfer is forcibly terminated
//   bus_to_mst   index of the master whose transfer last timed out
// ---------------------------------------------------------------------------
interface busarb_if;
    logic        m0_en;
    logic        m0_wr;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr;
    logic [31:0] m0_data_out;
    logic [31:0] m0_data_in;
    logic        m0_wt;

    logic        m1_en;
    logic        m1_wr;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr;
    logic [31:0] m1_data_out;
    logic [31:0] m1_data_in;
    logic        m1_wt;

    logic        bus_en;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_out;
    logic [31:0] bus_data_in;
    logic        bus_wt;

    logic        bus_to;
    logic        bus_to_mst;

    modport slave (
        input  m0_en, m0_wr, m0_size, m0_addr, m0_data_out,
        input  m1_en, m1_wr, m1_size, m1_addr, m1_data_out,
        input  bus_data_in, bus_wt,
        output m0_data_in, m0_wt, m1_data_in, m1_wt,
        output bus_en, bus_wr, bus_size, bus_addr, bus_data_out,
        output bus_to, bus_to_mst
    );

    modport master (
        output m0_en, m0_wr, m0_size, m0_addr, m0_data_out,
        output m1_en, m1_wr, m1_size, m1_addr, m1_data_out,
        output bus_data_in, bus_wt,
        input  m0_data_in, m0_wt, m1_data_in, m1_wt,
        input  bus_en, bus_wr, bus_size, bus_addr, bus_data_out,
        input  bus_to, bus_to_mst
    );
endinterface

// File: rtl/busarb.sv
// ---------------------------------------------------------------------------
// busarb
// Purpose : Two-master arbiter in front of the bus controller's CPU-side
//           port. Master 0 is the CPU, master 1 is a DMA-capable peripheral.
//           The bus is granted per transfer with round-robin fairness and a
//           burst limit, and a watchdog forcibly ends transfers that stall
//           for too long.
// Parameters:
//   MAX_BURST  max back-to-back completed transfers by the owner while the
//              other master is waiting (1..15)
//   TIMEOUT    max wait cycles of one transfer before forced termination;
//              0 disables the watchdog (0..255)
// Ports   :
//   clk        system clock
//   reset      synchronous, active-high reset
//   bif        busarb_if.slave: master requests/responses, bus controller
//              request/response, timeout pulse and sticky timeout master
// ---------------------------------------------------------------------------
module busarb #(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic     clk,
    input  logic     reset,
    busarb_if.slave  bif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIM    = 8'(TIMEOUT);
    localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
    localparam bit         TO_EN     = (TIMEOUT != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        w_last_grant_nxt;
    logic [3:0]  r_burst_cnt;
    logic [3:0]  w_burst_cnt_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_bus_to_mst;
    logic        w_bus_to_mst_nxt;

    logic        w_gnt;
    logic        w_own;
    logic        w_own_en;
    logic        w_oth_en;
    logic        w_done;
    logic        w_timeout;
    logic        w_complete;
    logic [4:0]  w_burst_inc;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Owner-relative view of the current transfer.
    assign w_gnt       = (r_state != IDLE);
    assign w_own       = (r_state == GNT1);
    assign w_own_en    = w_gnt & (w_own ? bif.m1_en : bif.m0_en);
    assign w_oth_en    = w_own ? bif.m0_en : bif.m1_en;
    assign w_done      = w_own_en & ~bif.bus_wt;
    // A genuine completion on the threshold cycle wins over the watchdog,
    // hence the bus_wt term.
    assign w_timeout   = TO_EN & w_own_en & bif.bus_wt & (r_wait_cnt == TO_LIM);
    assign w_complete  = w_done | w_timeout;
    assign w_burst_inc = {1'b0, r_burst_cnt} + 5'd1;

    // Bus and master-response routing; purely combinational from the owner.
    always_comb begin
        bif.bus_en       = 1'b0;
        bif.bus_wr       = 1'b0;
        bif.bus_size     = 2'd0;
        bif.bus_addr     = 32'd0;
        bif.bus_data_out = 32'd0;
        bif.m0_wt        = 1'b1;
        bif.m1_wt        = 1'b1;
        bif.m0_data_in   = 32'd0;
        bif.m1_data_in   = 32'd0;
        case (r_state)
            GNT0: begin
                bif.bus_en       = bif.m0_en;
                bif.bus_wr       = bif.m0_wr;
                bif.bus_size     = bif.m0_size;
                bif.bus_addr     = bif.m0_addr;
                bif.bus_data_out = bif.m0_data_out;
                bif.m0_wt        = w_timeout ? 1'b0 : bif.bus_wt;
                bif.m0_data_in   = w_timeout ? 32'd0 : bif.bus_data_in;
            end
            GNT1: begin
                bif.bus_en       = bif.m1_en;
                bif.bus_wr       = bif.m1_wr;
                bif.bus_size     = bif.m1_size;
                bif.bus_addr     = bif.m1_addr;
                bif.bus_data_out = bif.m1_data_out;
                bif.m1_wt        = w_timeout ? 1'b0 : bif.bus_wt;
                bif.m1_data_in   = w_timeout ? 32'd0 : bif.bus_data_in;
            end
            default: ;
        endcase
    end

    // The timeout master is visible in the same cycle as the pulse and held
    // in r_bus_to_mst afterwards.
    assign bif.bus_to     = w_timeout;
    assign bif.bus_to_mst = w_timeout ? w_own : r_bus_to_mst;

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_wait_cnt_nxt   = 8'd0;
        w_bus_to_mst_nxt = w_timeout ? w_own : r_bus_to_mst;
        case (r_state)
            IDLE: begin
                w_burst_cnt_nxt = 4'd0;
                if (bif.m0_en && bif.m1_en) begin
                    // Round robin: favour the master that did not own last.
                    w_state_nxt = r_last_grant ? GNT0 : GNT1;
                end else if (bif.m0_en) begin
                    w_state_nxt = GNT0;
                end else if (bif.m1_en) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!w_own_en) begin
                    // Owner released (possibly mid-transfer): hand over or idle.
                    w_state_nxt      = w_oth_en ? (w_own ? GNT0 : GNT1) : IDLE;
                    w_last_grant_nxt = w_own;
                    w_burst_cnt_nxt  = 4'd0;
                end else if (w_complete) begin
                    if (w_oth_en && (w_burst_inc >= BURST_LIM)) begin
                        w_state_nxt      = w_own ? GNT0 : GNT1;
                        w_last_grant_nxt = w_own;
                        w_burst_cnt_nxt  = 4'd0;
                    end else begin
                        w_burst_cnt_nxt  = sat_inc4(r_burst_cnt);
                    end
                end else begin
                    // Still waiting; cannot overflow because it fires at TO_LIM.
                    w_wait_cnt_nxt = TO_EN ? r_wait_cnt + 8'd1 : 8'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_wait_cnt   <= 8'd0;
            r_bus_to_mst <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_bus_to_mst <= w_bus_to_mst_nxt;
        end
    end

endmodule

// File: tb/tb_busarb.sv
// ---------------------------------------------------------------------------
// tb_busarb
// Purpose : Directed bench for busarb. Instance A runs MAX_BURST=1 with
//           TIMEOUT=8, instance B runs MAX_BURST=4 with the watchdog off.
//           Inputs change 1 time unit after the rising edge; outputs are
//           compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_busarb;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h3030_0000;
    localparam logic [31:0] D0 = 32'hA5A5_A5A5;
    localparam logic [31:0] D1 = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    busarb_if ifa ();
    busarb_if ifb ();

    busarb #(.MAX_BURST(1), .TIMEOUT(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bif   (ifa.slave)
    );

    busarb #(.MAX_BURST(4), .TIMEOUT(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bif   (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_a(input logic e0, input logic e1, input logic wt, input logic [31:0] din);
        ifa.m0_en       = e0;
        ifa.m1_en       = e1;
        ifa.bus_wt      = wt;
        ifa.bus_data_in = din;
    endtask

    task automatic set_b(input logic e0, input logic e1, input logic wt, input logic [31:0] din);
        ifb.m0_en       = e0;
        ifb.m1_en       = e1;
        ifb.bus_wt      = wt;
        ifb.bus_data_in = din;
    endtask

    initial begin
        logic any_to;
        logic any_rdy;

        reset = 1'b1;
        ifa.m0_wr = 1'b1; ifa.m0_size = 2'd2; ifa.m0_addr = A0; ifa.m0_data_out = D0;
        ifa.m1_wr = 1'b0; ifa.m1_size = 2'd1; ifa.m1_addr = A1; ifa.m1_data_out = D1;
        ifb.m0_wr = 1'b1; ifb.m0_size = 2'd2; ifb.m0_addr = A0; ifb.m0_data_out = D0;
        ifb.m1_wr = 1'b0; ifb.m1_size = 2'd1; ifb.m1_addr = A1; ifb.m1_data_out = D1;
        set_a(1'b0, 1'b0, 1'b0, 32'd0);
        set_b(1'b0, 1'b0, 1'b0, 32'd0);
        nxt();
        nxt();
        reset = 1'b0;
        mid();
        chkb("rst_bus_en", ifa.bus_en, 1'b0);
        chkb("rst_m0_wt", ifa.m0_wt, 1'b1);
        chkb("rst_m1_wt", ifa.m1_wt, 1'b1);
        chk ("rst_m0_din", ifa.m0_data_in, 32'd0);
        chkb("rst_bus_to", ifa.bus_to, 1'b0);
        chkb("rst_to_mst", ifa.bus_to_mst, 1'b0);
        chkb("rst_b_bus_en", ifb.bus_en, 1'b0);
        nxt();

        // Reset in the middle of a stuck m1 transfer.
        set_a(1'b0, 1'b1, 1'b1, 32'd0);
        mid(); chkb("idle_bus_en", ifa.bus_en, 1'b0); nxt();
        mid();
        chkb("g1_bus_en", ifa.bus_en, 1'b1);
        chk ("g1_addr", ifa.bus_addr, A1);
        chkb("g1_m1_wt", ifa.m1_wt, 1'b1);
        nxt();
        reset = 1'b1;
        mid(); nxt();
        reset = 1'b0;
        set_a(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        mid();
        chkb("mrst_bus_en", ifa.bus_en, 1'b0);
        chkb("mrst_m0_wt", ifa.m0_wt, 1'b1);
        chkb("mrst_m1_wt", ifa.m1_wt, 1'b1);
        chkb("mrst_bus_to", ifa.bus_to, 1'b0);
        nxt();

        // Both request, zero-wait device, MAX_BURST=1: m0 first, then alternate.
        mid();
        chkb("rr1_m0_wt", ifa.m0_wt, 1'b0);
        chkb("rr1_m1_wt", ifa.m1_wt, 1'b1);
        chk ("rr1_addr", ifa.bus_addr, A0);
        chkb("rr1_wr", ifa.bus_wr, 1'b1);
        chk ("rr1_size", 32'(ifa.bus_size), 32'd2);
        chk ("rr1_dout", ifa.bus_data_out, D0);
        chk ("rr1_m0_din", ifa.m0_data_in, 32'h1234_5678);
        chk ("rr1_m1_din", ifa.m1_data_in, 32'd0);
        nxt();
        mid();
        chkb("rr2_m1_wt", ifa.m1_wt, 1'b0);
        chkb("rr2_m0_wt", ifa.m0_wt, 1'b1);
        chk ("rr2_addr", ifa.bus_addr, A1);
        chk ("rr2_m1_din", ifa.m1_data_in, 32'h1234_5678);
        chk ("rr2_m0_din", ifa.m0_data_in, 32'd0);
        nxt();
        mid();
        chkb("rr3_m0_wt", ifa.m0_wt, 1'b0);
        chk ("rr3_addr", ifa.bus_addr, A0);
        nxt();
        set_a(1'b0, 1'b0, 1'b0, 32'd0);
        mid(); chkb("drop_bus_en", ifa.bus_en, 1'b0); nxt();

        // Single m1 request, three wait cycles then completion.
        set_a(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        mid(); chkb("w_idle_m1_wt", ifa.m1_wt, 1'b1); nxt();
        for (int k = 0; k < 3; k++) begin
            mid();
            chkb("w_m1_wt", ifa.m1_wt, 1'b1);
            chk ("w_addr", ifa.bus_addr, A1);
            chkb("w_m0_wt", ifa.m0_wt, 1'b1);
            nxt();
        end
        ifa.bus_wt = 1'b0;
        mid();
        chkb("w_done_m1_wt", ifa.m1_wt, 1'b0);
        chk ("w_done_din", ifa.m1_data_in, 32'hDEAD_BEEF);
        chkb("w_done_m0_wt", ifa.m0_wt, 1'b1);
        nxt();
        set_a(1'b0, 1'b0, 1'b0, 32'd0);
        mid(); nxt();

        // TIMEOUT=8: m0 stuck with m1 pending.
        set_a(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
        mid(); nxt();
        for (int k = 1; k <= 8; k++) begin
            mid();
            chkb("to0_m0_wt", ifa.m0_wt, 1'b1);
            chkb("to0_bus_to", ifa.bus_to, 1'b0);
            chkb("to0_m1_wt", ifa.m1_wt, 1'b1);
            nxt();
        end
        mid();
        chkb("to0_fire_wt", ifa.m0_wt, 1'b0);
        chk ("to0_fire_din", ifa.m0_data_in, 32'd0);
        chkb("to0_fire_to", ifa.bus_to, 1'b1);
        chkb("to0_fire_mst", ifa.bus_to_mst, 1'b0);
        nxt();
        ifa.m0_en = 1'b0;
        mid();
        chkb("to1_start_to", ifa.bus_to, 1'b0);
        chkb("to1_start_en", ifa.bus_en, 1'b1);
        chk ("to1_start_addr", ifa.bus_addr, A1);
        chkb("to1_start_wt", ifa.m1_wt, 1'b1);
        nxt();
        for (int k = 2; k <= 8; k++) begin
            mid();
            chkb("to1_m1_wt", ifa.m1_wt, 1'b1);
            nxt();
        end
        mid();
        chkb("to1_fire_wt", ifa.m1_wt, 1'b0);
        chk ("to1_fire_din", ifa.m1_data_in, 32'd0);
        chkb("to1_fire_to", ifa.bus_to, 1'b1);
        chkb("to1_fire_mst", ifa.bus_to_mst, 1'b1);
        nxt();
        ifa.m1_en = 1'b0;
        mid();
        chkb("to1_after_to", ifa.bus_to, 1'b0);
        chkb("to1_sticky_mst", ifa.bus_to_mst, 1'b1);
        nxt();

        // Completion on the threshold cycle beats the watchdog.
        set_a(1'b1, 1'b0, 1'b1, 32'h0000_55AA);
        mid(); nxt();
        for (int k = 1; k <= 8; k++) begin
            mid();
            chkb("tie_m0_wt", ifa.m0_wt, 1'b1);
            nxt();
        end
        ifa.bus_wt = 1'b0;
        mid();
        chkb("tie_m0_wt0", ifa.m0_wt, 1'b0);
        chk ("tie_din", ifa.m0_data_in, 32'h0000_55AA);
        chkb("tie_bus_to", ifa.bus_to, 1'b0);
        chkb("tie_mst", ifa.bus_to_mst, 1'b1);
        nxt();
        set_a(1'b0, 1'b0, 1'b0, 32'd0);

        // MAX_BURST=4: m0 streams, m1 joins on the second grant cycle.
        set_b(1'b1, 1'b0, 1'b0, 32'd0);
        mid(); nxt();
        mid();
        chkb("bu1_m0_wt", ifb.m0_wt, 1'b0);
        chk ("bu1_addr", ifb.bus_addr, A0);
        nxt();
        ifb.m1_en = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            mid();
            chkb("bu_m0_wt", ifb.m0_wt, 1'b0);
            chkb("bu_m1_wt", ifb.m1_wt, 1'b1);
            chk ("bu_addr", ifb.bus_addr, A0);
            nxt();
        end
        mid();
        chkb("bu_sw_en", ifb.bus_en, 1'b1);
        chkb("bu_sw_m1_wt", ifb.m1_wt, 1'b0);
        chkb("bu_sw_m0_wt", ifb.m0_wt, 1'b1);
        chk ("bu_sw_addr", ifb.bus_addr, A1);
        nxt();
        set_b(1'b0, 1'b0, 1'b0, 32'd0);
        mid(); nxt();

        // TIMEOUT=0: stuck device never triggers the watchdog.
        set_b(1'b1, 1'b0, 1'b1, 32'd0);
        mid(); nxt();
        any_to  = 1'b0;
        any_rdy = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            mid();
            any_to  = any_to | ifb.bus_to;
            any_rdy = any_rdy | ~ifb.m0_wt;
            nxt();
        end
        chkb("nto_bus_to", any_to, 1'b0);
        chkb("nto_m0_rdy", any_rdy, 1'b0);
        mid();
        chkb("nto_bus_en", ifb.bus_en, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
